// File: rtl/if_fetch_unit_if.sv
// IF-stage signal bundle: instruction-memory port, EX redirect and the ID beat handshake.
// Latency: none (wires only).
// Backpressure: id_ready from ID stalls id_valid beats; master = fetch unit, slave = its neighbours.
interface if_fetch_unit_if;
   // instruction memory port (1-cycle synchronous read)
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   // redirect from EX
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   // beat towards ID
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      input  id_ready,
      output id_valid,
      output id_pc,
      output id_instr,
      output id_pc_plus4
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output redirect_valid,
      output redirect_pc,
      output id_ready,
      input  id_valid,
      input  id_pc,
      input  id_instr,
      input  id_pc_plus4
   );
endinterface

// File: rtl/if_fetch_unit.sv
// IF fetch unit: owns the PC, drives imem_addr, delivers ordered {pc, instr} beats to ID.
// Latency: 2 edges from reset release or redirect to first id_valid; 1 beat/cycle steady state.
// Backpressure: 1-entry skid absorbs the response in flight when ID stalls; issue pauses until room.
// Optional: define IF_FETCH_PERF_EN to add perf_fetched / perf_flushes event counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clock,
   input  logic           reset_n,
   if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]    perf_fetched,
   output logic [15:0]    perf_flushes
`endif
);

   // fetch address and the request whose data is on imem_rdata this cycle
   logic [31:0] r_fetch_pc;
   logic        r_inflight;
   logic [31:0] r_inflight_pc;

   // output slot, directly visible on id_*
   logic        r_out_valid;
   logic [31:0] r_out_pc;
   logic [31:0] r_out_pc4;
   logic [31:0] r_out_instr;

   // skid slot, always younger than the output slot
   logic        r_skid_valid;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_instr;

   logic        w_consume;
   logic        w_out_free;
   logic        w_issue;
   logic [31:0] w_fetch_pc_d;
   logic        w_out_valid_d;
   logic        w_out_load;
   logic [31:0] w_out_pc_d;
   logic [31:0] w_out_instr_d;
   logic        w_skid_valid_d;
   logic        w_skid_load;
   logic [31:0] w_skid_pc_d;
   logic [31:0] w_skid_instr_d;

   assign w_consume  = r_out_valid & bus.id_ready;
   assign w_out_free = ~r_out_valid | w_consume;

   // Stop issuing when the response already in flight would need the skid slot,
   // or when the skid slot is occupied; a redirect replaces this edge's issue.
   assign w_issue = ~r_skid_valid
                  & ~(r_out_valid & ~bus.id_ready & r_inflight)
                  & ~bus.redirect_valid;

   // Next fetch address: redirect target (word aligned), sequential step, or hold.
   always_comb begin
      w_fetch_pc_d = r_fetch_pc;
      if (bus.redirect_valid) begin
         w_fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      end else if (w_issue) begin
         w_fetch_pc_d = r_fetch_pc + 32'd4;
      end
   end

   // Slot placement: output takes skid before the response so program order holds.
   always_comb begin
      w_out_valid_d  = r_out_valid;
      w_out_load     = 1'b0;
      w_out_pc_d     = r_out_pc;
      w_out_instr_d  = r_out_instr;
      w_skid_valid_d = r_skid_valid;
      w_skid_load    = 1'b0;
      w_skid_pc_d    = r_skid_pc;
      w_skid_instr_d = r_skid_instr;
      if (bus.redirect_valid) begin
         w_out_valid_d  = 1'b0;
         w_skid_valid_d = 1'b0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            w_out_valid_d  = 1'b1;
            w_out_load     = 1'b1;
            w_out_pc_d     = r_skid_pc;
            w_out_instr_d  = r_skid_instr;
            w_skid_valid_d = r_inflight;
            w_skid_load    = r_inflight;
            w_skid_pc_d    = r_inflight_pc;
            w_skid_instr_d = bus.imem_rdata;
         end else if (r_inflight) begin
            w_out_valid_d  = 1'b1;
            w_out_load     = 1'b1;
            w_out_pc_d     = r_inflight_pc;
            w_out_instr_d  = bus.imem_rdata;
         end else begin
            w_out_valid_d  = 1'b0;
         end
      end else if (r_inflight) begin
         // output stalled: the response parks in skid (issue rule guarantees it is empty)
         w_skid_valid_d = 1'b1;
         w_skid_load    = 1'b1;
         w_skid_pc_d    = r_inflight_pc;
         w_skid_instr_d = bus.imem_rdata;
      end
   end

   // Fetch PC and in-flight tracking.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= 32'd0;
      end else begin
         r_fetch_pc <= w_fetch_pc_d;
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
         end
      end
   end

   // Output and skid slot registers; pc+4 is registered alongside so it reads 0 out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_pc     <= 32'd0;
         r_out_pc4    <= 32'd0;
         r_out_instr  <= 32'd0;
         r_skid_valid <= 1'b0;
         r_skid_pc    <= 32'd0;
         r_skid_instr <= 32'd0;
      end else begin
         r_out_valid  <= w_out_valid_d;
         r_skid_valid <= w_skid_valid_d;
         if (w_out_load) begin
            r_out_pc    <= w_out_pc_d;
            r_out_pc4   <= w_out_pc_d + 32'd4;
            r_out_instr <= w_out_instr_d;
         end
         if (w_skid_load) begin
            r_skid_pc    <= w_skid_pc_d;
            r_skid_instr <= w_skid_instr_d;
         end
      end
   end

   assign bus.imem_addr   = r_fetch_pc;
   assign bus.id_valid    = r_out_valid;
   assign bus.id_pc       = r_out_pc;
   assign bus.id_instr    = r_out_instr;
   assign bus.id_pc_plus4 = r_out_pc4;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [15:0] r_perf_flushes;

   // Event counters: handshakes (including one coincident with a redirect) and redirect edges.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_fetched <= 32'd0;
         r_perf_flushes <= 16'd0;
      end else begin
         r_perf_fetched <= r_perf_fetched + {31'd0, w_consume};
         r_perf_flushes <= r_perf_flushes + {15'd0, bus.redirect_valid};
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Upstream neighbour of the instruction memory in the IF stage: owns the PC, drives the memory address and absorbs its 1-cycle synchronous read latency.
- Delivers ordered {pc, instr} beats to ID over a valid/ready handshake.
- Handles ID back-pressure with a 1-entry skid buffer.
- Handles branch/jump redirects from EX by flushing everything in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
clock  in  1  system clock, all state on posedge
reset_n  in  1  asynchronous, active-low reset
imem_addr  out  32  byte address to instruction memory; sampled by memory at posedge, data returned after that edge
imem_rdata  in  32  instruction word from memory (valid the cycle after the address was sampled)
redirect_valid  in  1  taken branch/jump from EX; flush and refetch
redirect_pc  in  32  redirect target
id_ready  in  1  ID accepts a beat this cycle
id_valid  out  1  beat on id_* is valid
id_pc  out  32  PC of delivered instruction
id_instr  out  32  delivered instruction
id_pc_plus4  out  32  id_pc + 4, wraps modulo 2^32

Behaviour:
- State registers:
  - fetch_pc_q drives imem_addr directly, with no combinational path from inputs.
  - inflight_q / inflight_pc_q: a request was sampled last edge, so imem_rdata currently carries its data.
  - Output slot: out_valid_q, out_pc_q, out_instr_q drive id_valid, id_pc, id_instr.
  - Skid slot: skid_valid_q, skid_pc_q, skid_instr_q.
- Reset, asynchronous on reset_n low:
  - fetch_pc_q = RESET_PC.
  - inflight_q, out_valid_q, skid_valid_q = 0.
  - id_valid = 0; id_pc, id_instr = 0; id_pc_plus4 = 0.
  - Reset mid-operation discards all in-flight and buffered beats.
- Issue rule: an edge issues a request iff skid_valid_q = 0 and NOT (out_valid_q & !id_ready & inflight_q) and redirect_valid = 0.
- On issue:
  - inflight_q <= 1, inflight_pc_q <= fetch_pc_q.
  - fetch_pc_q <= fetch_pc_q + 4, wrapping 32'hFFFF_FFFC -> 0.
- Without issue: inflight_q <= 0 and fetch_pc_q holds.
- Response placement, when inflight_q = 1 at an edge:
  - The output slot loads from skid first (if skid_valid_q) and otherwise from the response.
  - The output slot loads only if it is empty or consumed (id_valid & id_ready) this cycle.
  - A response that cannot enter the output slot goes to skid.
  - Program order is always preserved: output, then skid, then in-flight.
- Consume without a new fill: out_valid_q <= 0.
- id_pc/id_instr hold stable while id_valid & !id_ready.
- Redirect has the highest priority. At an edge with redirect_valid = 1:
  - fetch_pc_q <= {redirect_pc[31:2], 2'b00}.
  - inflight_q, out_valid_q, skid_valid_q <= 0.
  - A simultaneous handshake on id_* still counts as consumed by ID.
  - The cycle after a redirect: imem_addr = target; data appears at id_* two edges after the redirect edge.
- Latency:
  - First id_valid after reset release: 2 edges (issue edge, capture edge).
  - Steady state with id_ready = 1: one beat per cycle, PCs contiguous.
- Occupancy never exceeds 2 buffered beats (output + skid); no data is dropped under any id_ready pattern.

Optional Feature:
- IF_FETCH_PERF_EN defined: adds two output ports.
  - perf_fetched (32): count of id handshakes.
  - perf_flushes (16): count of redirect edges.
  - Both reset to 0, wrap on overflow, and increment in the same edge as the event.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, id_ready = 1, memory model returns word = addr ^ 32'hA5A5_0000 -> id_valid rises on 2nd edge with id_pc = 0, then pcs 4, 8, 12 on consecutive cycles; id_pc_plus4 = id_pc + 4.
- Hold id_ready = 0 for 4 cycles in steady stream -> id_pc frozen at 8, imem_addr stalls at 16 (no further issue), skid holds 12; on release beats 8, 12, 16 delivered in order with no gap or duplicate.
- Assert redirect_valid with redirect_pc = 32'h0000_0040 while output and skid full -> all beats flushed, next id_valid beat has id_pc = 0x40 two edges later, followed by 0x44.
- Redirect_pc = 32'h0000_0043 -> fetch resumes at 0x40; redirect coincident with id handshake -> handshaked beat counted once, nothing older delivered after.
- RESET_PC = 32'hFFFF_FFF8, id_ready = 1 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; id_pc_plus4 of 0xFFFF_FFFC = 0.
- Assert reset_n low mid-stream (between edges) -> id_valid drops immediately, restart delivers RESET_PC first; with IF_FETCH_PERF_EN, counters read 0 after reset and match handshake/redirect totals after a 20-cycle random run.
